// File: rtl/coin_pulse_gen.sv
// Coin-slot front end: synchronise, debounce and edge-qualify two raw coin
// sensors, then emit mutually exclusive credit pulses, reject pulses and
// stuck-sensor fault levels for the vending FSM.
module coin_pulse_gen #(
   parameter int unsigned DB_CYCLES    = 4,
   parameter int unsigned STUCK_CYCLES = 64,
   parameter int unsigned CNT_W        = 7
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_half,
   input  logic raw_one,
   input  logic inhibit,
   output logic half,
   output logic one,
   output logic reject,
   output logic fault_half,
   output logic fault_one
);

   localparam int unsigned NCH = 2;
   localparam logic [CNT_W-1:0] DB_C    = CNT_W'(DB_CYCLES);
   localparam logic [CNT_W-1:0] STUCK_C = CNT_W'(STUCK_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CONFIRM,
      ST_HELD,
      ST_RELEASE,
      ST_FAULT
   } state_e;

   // Channel 0 is the half-unit slot, channel 1 the one-unit slot.
   logic [NCH-1:0]   raw_c;
   logic [NCH-1:0]   s1_q, s1_d;
   logic [NCH-1:0]   s2_q, s2_d;
   state_e           state_q [NCH];
   state_e           state_d [NCH];
   logic [CNT_W-1:0] cnt_q [NCH];
   logic [CNT_W-1:0] cnt_d [NCH];
   logic [CNT_W-1:0] cnt_inc_c [NCH];
   logic [NCH-1:0]   fault_q, fault_d;
   logic [NCH-1:0]   accept_c;

   logic pend_half_q, pend_half_d;
   logic pend_one_q, pend_one_d;
   logic rej_pend_q, rej_pend_d;
   logic half_q, half_d;
   logic one_q, one_d;
   logic reject_q, reject_d;
   logic rej_half_c, rej_one_c;

   assign raw_c = {raw_one, raw_half};

   // Synchroniser and per-channel debounce / stuck-detect state machines.
   always_comb begin
      s1_d = raw_c;
      s2_d = s1_q;
      for (int ch = 0; ch < NCH; ch++) begin
         state_d[ch]   = state_q[ch];
         cnt_d[ch]     = cnt_q[ch];
         accept_c[ch]  = 1'b0;
         cnt_inc_c[ch] = (cnt_q[ch] == CNT_MAX) ? cnt_q[ch] : cnt_q[ch] + CNT_W'(1);
         case (state_q[ch])
            ST_IDLE: begin
               cnt_d[ch] = '0;
               if (s2_q[ch]) begin
                  state_d[ch] = ST_CONFIRM;
                  cnt_d[ch]   = CNT_W'(1);
               end
            end
            ST_CONFIRM: begin
               if (!s2_q[ch]) begin
                  state_d[ch] = ST_IDLE;
                  cnt_d[ch]   = '0;
               end else if (cnt_inc_c[ch] == DB_C) begin
                  state_d[ch]  = ST_HELD;
                  cnt_d[ch]    = '0;
                  accept_c[ch] = 1'b1;
               end else begin
                  cnt_d[ch] = cnt_inc_c[ch];
               end
            end
            ST_HELD: begin
               if (!s2_q[ch]) begin
                  state_d[ch] = ST_RELEASE;
                  cnt_d[ch]   = CNT_W'(1);
               end else if (cnt_inc_c[ch] == STUCK_C) begin
                  state_d[ch] = ST_FAULT;
                  cnt_d[ch]   = '0;
               end else begin
                  cnt_d[ch] = cnt_inc_c[ch];
               end
            end
            ST_RELEASE: begin
               if (s2_q[ch]) begin
                  // Short low glitch: coin still present, no new accept.
                  state_d[ch] = ST_HELD;
                  cnt_d[ch]   = '0;
               end else if (cnt_inc_c[ch] == DB_C) begin
                  state_d[ch] = ST_IDLE;
                  cnt_d[ch]   = '0;
               end else begin
                  cnt_d[ch] = cnt_inc_c[ch];
               end
            end
            ST_FAULT: begin
               // Recover only after a clean debounced low; never credits.
               if (s2_q[ch]) begin
                  cnt_d[ch] = '0;
               end else if (cnt_inc_c[ch] == DB_C) begin
                  state_d[ch] = ST_IDLE;
                  cnt_d[ch]   = '0;
               end else begin
                  cnt_d[ch] = cnt_inc_c[ch];
               end
            end
            default: begin
               state_d[ch] = ST_IDLE;
               cnt_d[ch]   = '0;
            end
         endcase
         fault_d[ch] = (state_d[ch] == ST_FAULT);
      end
   end

   // Output stage: credit pending bits with half-first arbitration, rejects.
   always_comb begin
      rej_half_c = accept_c[0] & inhibit;
      rej_one_c  = accept_c[1] & inhibit;
      half_d     = pend_half_q;
      one_d      = pend_one_q & ~pend_half_q;
      pend_half_d = accept_c[0] & ~inhibit;
      pend_one_d  = (accept_c[1] & ~inhibit) | (pend_one_q & pend_half_q);
      reject_d    = rej_half_c | rej_one_c | rej_pend_q;
      rej_pend_d  = rej_half_c & rej_one_c;
   end

   // All state registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q        <= '0;
         s2_q        <= '0;
         fault_q     <= '0;
         pend_half_q <= 1'b0;
         pend_one_q  <= 1'b0;
         rej_pend_q  <= 1'b0;
         half_q      <= 1'b0;
         one_q       <= 1'b0;
         reject_q    <= 1'b0;
         for (int ch = 0; ch < NCH; ch++) begin
            state_q[ch] <= ST_IDLE;
            cnt_q[ch]   <= '0;
         end
      end else begin
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         fault_q     <= fault_d;
         pend_half_q <= pend_half_d;
         pend_one_q  <= pend_one_d;
         rej_pend_q  <= rej_pend_d;
         half_q      <= half_d;
         one_q       <= one_d;
         reject_q    <= reject_d;
         for (int ch = 0; ch < NCH; ch++) begin
            state_q[ch] <= state_d[ch];
            cnt_q[ch]   <= cnt_d[ch];
         end
      end
   end

   assign half       = half_q;
   assign one        = one_q;
   assign reject     = reject_q;
   assign fault_half = fault_q[0];
   assign fault_one  = fault_q[1];

endmodule

// File: tb/tb_coin_pulse_gen.sv
// Bench for coin_pulse_gen: directed scenarios plus randomized traffic, all
// compared each cycle against a run-length / queue reference model.
module tb_coin_pulse_gen;

   localparam int unsigned DB    = 4;
   localparam int unsigned STUCK = 64;
   localparam int unsigned CW    = 7;

   logic clk = 1'b0;
   logic reset, raw_half, raw_one, inhibit;
   logic half, one, reject, fault_half, fault_one;

   int n_cmp  = 0;
   int n_fail = 0;

   coin_pulse_gen #(.DB_CYCLES(DB), .STUCK_CYCLES(STUCK), .CNT_W(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .raw_half   (raw_half),
      .raw_one    (raw_one),
      .inhibit    (inhibit),
      .half       (half),
      .one        (one),
      .reject     (reject),
      .fault_half (fault_half),
      .fault_one  (fault_one)
   );

   always #5 clk = ~clk;

   // Reference model: debounced level per channel from consecutive-sample
   // run lengths; credits and rejects are FIFOs drained one per cycle.
   bit   m_s1 [2];
   bit   m_s2 [2];
   bit   m_prev [2];
   bit   m_lvl [2];
   bit   m_flt [2];
   int   m_hi [2];
   int   m_lo [2];
   int   m_held [2];
   int   credq [$];
   int   rejq [$];
   logic [4:0] exp_v;

   function automatic logic [4:0] act_v();
      return {half, one, reject, fault_half, fault_one};
   endfunction

   task automatic model_step();
      bit acc [2];
      bit rv [2];
      bit s;
      bit e_h, e_o, e_r;
      rv[0] = raw_half;
      rv[1] = raw_one;
      if (reset) begin
         for (int ch = 0; ch < 2; ch++) begin
            m_s1[ch] = 0; m_s2[ch] = 0; m_prev[ch] = 0; m_lvl[ch] = 0;
            m_flt[ch] = 0; m_hi[ch] = 0; m_lo[ch] = 0; m_held[ch] = 0;
         end
         credq.delete();
         rejq.delete();
         exp_v = '0;
         return;
      end
      for (int ch = 0; ch < 2; ch++) begin
         acc[ch] = 0;
         s = m_s2[ch];
         if (s) begin m_hi[ch]++; m_lo[ch] = 0; end
         else   begin m_lo[ch]++; m_hi[ch] = 0; end
         if (m_flt[ch]) begin
            if (m_lo[ch] == DB) begin m_flt[ch] = 0; m_lvl[ch] = 0; end
         end else if (!m_lvl[ch]) begin
            if (m_hi[ch] == DB) begin m_lvl[ch] = 1; acc[ch] = 1; m_held[ch] = 0; end
         end else begin
            if (!s) begin
               if (m_lo[ch] == DB) m_lvl[ch] = 0;
            end else if (!m_prev[ch]) begin
               m_held[ch] = 0;
            end else begin
               m_held[ch]++;
               if (m_held[ch] == STUCK) m_flt[ch] = 1;
            end
         end
         m_prev[ch] = s;
      end
      e_h = 0; e_o = 0; e_r = 0;
      if (credq.size() > 0) begin
         if (credq[0] == 0) e_h = 1; else e_o = 1;
         void'(credq.pop_front());
      end
      for (int ch = 0; ch < 2; ch++) begin
         if (acc[ch] && !inhibit) credq.push_back(ch);
         if (acc[ch] && inhibit)  rejq.push_back(ch);
      end
      if (rejq.size() > 0) begin
         e_r = 1;
         void'(rejq.pop_front());
      end
      exp_v = {e_h, e_o, e_r, m_flt[0], m_flt[1]};
      for (int ch = 0; ch < 2; ch++) begin
         m_s2[ch] = m_s1[ch];
         m_s1[ch] = rv[ch];
      end
   endtask

   // Apply one cycle of inputs, advance the model, sample 1 after the edge.
   task automatic drive(input logic rst, input logic rh, input logic ro, input logic inh);
      reset = rst; raw_half = rh; raw_one = ro; inhibit = inh;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b0);
         n_cmp++;
         if (act_v() !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_state cyc %0d: got %b want %b", i, act_v(), 5'b0);
         end
      end
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_latency();
      logic [4:0] e;
      for (int i = 0; i < 30; i++) begin
         drive(1'b0, i < 20, 1'b0, 1'b0);
         e = '0;
         if (i == DB + 2) e[4] = 1'b1;
         n_cmp++;
         if (act_v() !== e || act_v() !== exp_v) begin
            n_fail++;
            $display("FAIL latency cyc %0d: got %b want %b model %b", i, act_v(), e, exp_v);
         end
      end
   endtask

   task automatic test_bounce();
      logic [4:0] e;
      logic r;
      for (int i = 0; i < 21; i++) begin
         r = (i < 3) || (i >= 6 && i < 9);
         drive(1'b0, 1'b0, r, 1'b0);
         n_cmp++;
         if (act_v() !== 5'b0 || exp_v !== 5'b0) begin
            n_fail++;
            $display("FAIL bounce cyc %0d: got %b want %b model %b", i, act_v(), 5'b0, exp_v);
         end
      end
      for (int i = 0; i < 24; i++) begin
         drive(1'b0, 1'b0, i < 12, 1'b0);
         e = '0;
         if (i == DB + 2) e[3] = 1'b1;
         n_cmp++;
         if (act_v() !== e || act_v() !== exp_v) begin
            n_fail++;
            $display("FAIL bounce_then_press cyc %0d: got %b want %b model %b", i, act_v(), e, exp_v);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] e;
      for (int i = 0; i < 24; i++) begin
         drive(1'b0, i < 12, i < 12, 1'b0);
         e = '0;
         if (i == DB + 2) e[4] = 1'b1;
         if (i == DB + 3) e[3] = 1'b1;
         n_cmp++;
         if (act_v() !== e || act_v() !== exp_v || (half && one)) begin
            n_fail++;
            $display("FAIL simultaneous cyc %0d: got %b want %b model %b", i, act_v(), e, exp_v);
         end
      end
   endtask

   task automatic test_inhibit();
      logic [4:0] e;
      for (int i = 0; i < 24; i++) begin
         drive(1'b0, 1'b0, i < 12, 1'b1);
         e = '0;
         if (i == DB + 1) e[2] = 1'b1;
         n_cmp++;
         if (act_v() !== e || act_v() !== exp_v) begin
            n_fail++;
            $display("FAIL inhibit_reject cyc %0d: got %b want %b model %b", i, act_v(), e, exp_v);
         end
      end
      for (int i = 0; i < 24; i++) begin
         drive(1'b0, 1'b0, i < 12, 1'b0);
         e = '0;
         if (i == DB + 2) e[3] = 1'b1;
         n_cmp++;
         if (act_v() !== e || act_v() !== exp_v) begin
            n_fail++;
            $display("FAIL inhibit_off cyc %0d: got %b want %b model %b", i, act_v(), e, exp_v);
         end
      end
   endtask

   task automatic test_stuck();
      logic [4:0] e;
      for (int i = 0; i < 100; i++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0);
         e = '0;
         if (i == DB + 2) e[4] = 1'b1;
         if (i >= DB + 1 + STUCK) e[1] = 1'b1;
         n_cmp++;
         if (act_v() !== e || act_v() !== exp_v) begin
            n_fail++;
            $display("FAIL stuck_hold cyc %0d: got %b want %b model %b", i, act_v(), e, exp_v);
         end
      end
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0);
         e = '0;
         if (i < DB + 1) e[1] = 1'b1;
         n_cmp++;
         if (act_v() !== e || act_v() !== exp_v) begin
            n_fail++;
            $display("FAIL stuck_release cyc %0d: got %b want %b model %b", i, act_v(), e, exp_v);
         end
      end
      for (int i = 0; i < 24; i++) begin
         drive(1'b0, i < 12, 1'b0, 1'b0);
         e = '0;
         if (i == DB + 2) e[4] = 1'b1;
         n_cmp++;
         if (act_v() !== e || act_v() !== exp_v) begin
            n_fail++;
            $display("FAIL stuck_repress cyc %0d: got %b want %b model %b", i, act_v(), e, exp_v);
         end
      end
   endtask

   task automatic test_reset_mid();
      // Reset while half is still in debounce confirmation.
      for (int i = 0; i < 20; i++) begin
         drive(i == 3, i < 3, 1'b0, 1'b0);
         n_cmp++;
         if (act_v() !== 5'b0 || exp_v !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_confirm cyc %0d: got %b want %b model %b", i, act_v(), 5'b0, exp_v);
         end
      end
      // Reset on the edge where the one-credit would have been issued.
      for (int i = 0; i < 20; i++) begin
         drive(i == DB + 2, 1'b0, i < DB + 2, 1'b0);
         n_cmp++;
         if (act_v() !== 5'b0 || exp_v !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_pending cyc %0d: got %b want %b model %b", i, act_v(), 5'b0, exp_v);
         end
      end
   endtask

   task automatic test_random();
      logic lv [2];
      int   rem [2];
      logic inh;
      logic rst;
      lv[0] = 0; lv[1] = 0; rem[0] = 3; rem[1] = 7; inh = 0;
      for (int i = 0; i < 3000; i++) begin
         for (int ch = 0; ch < 2; ch++) begin
            if (rem[ch] == 0) begin
               lv[ch] = ~lv[ch];
               if ($urandom_range(0, 14) == 0) rem[ch] = $urandom_range(60, 80);
               else rem[ch] = $urandom_range(1, 10);
            end
            rem[ch]--;
         end
         if ($urandom_range(0, 7) == 0) inh = ~inh;
         rst = ($urandom_range(0, 399) == 0);
         drive(rst, lv[0], lv[1], inh);
         n_cmp++;
         if (act_v() !== exp_v || (half && one)) begin
            n_fail++;
            $display("FAIL random cyc %0d: got %b want %b", i, act_v(), exp_v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_bounce();
      test_back_to_back();
      test_inhibit();
      test_stuck();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
